bitwise_stream_unit: RTL and testbench

- Responder side of the bitwise operand interface. Accepts operand pairs plus an opcode over a valid/ready handshake, computes the 32-bit bitwise result, and buffers results in an in-order output FIFO drained by a second valid/ready handshake.
- Sits between an operand issuer (sequencer or bench driver) and the ALU result bus.
- Provides back-pressure and a count of completed operations.

---
 rtl/bitwise_stream_unit.sv | 157 +++++++++++++++
 tb/tb_bitwise_stream_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_stream_unit.sv
// -----------------------------------------------------------------------------
// bitwise_stream_unit
//
// Responder for the bitwise operand interface. An operand pair plus opcode is
// accepted over an in_valid/in_ready handshake. The 32-bit bitwise result is
// computed combinationally and written, together with its opcode, into a small
// in-order FIFO. A second valid/ready handshake drains the FIFO. A saturating
// counter tracks how many results have been popped.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair / opcode valid
//   in_ready   unit can accept a transfer (depends on stored state only)
//   op         00 AND, 01 OR, 10 XOR, 11 NOR
//   i_1, i_2   operands
//   enable     0 forces the pushed result to zero
//   out_valid  FIFO head holds a result
//   out_ready  consumer takes the head this cycle
//   o          result at FIFO head (zero while empty)
//   o_op       opcode that produced the head result (zero while empty)
//   done_cnt   number of results popped, saturating
// -----------------------------------------------------------------------------
module bitwise_stream_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] i_1,
    input  logic [WIDTH-1:0] i_2,
    input  logic             enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic [1:0]       o_op,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    // FIFO storage: one result word and one opcode per entry.
    logic [WIDTH-1:0] res_mem [DEPTH];
    logic [1:0]       op_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [OCC_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] done_cnt_reg, done_cnt_next;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] result_next;

    // ------------------------------------------------------------------
    // Handshake qualification. Both flags come from stored occupancy only,
    // so a full FIFO stays closed to pushes even in a cycle that pops.
    // ------------------------------------------------------------------
    assign in_ready  = (count_reg < OCC_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Result function.
    // ------------------------------------------------------------------
    always_comb begin
        result_next = '0;
        if (enable) begin
            case (op)
                OP_AND:  result_next = i_1 & i_2;
                OP_OR:   result_next = i_1 | i_2;
                OP_XOR:  result_next = i_1 ^ i_2;
                OP_NOR:  result_next = ~(i_1 | i_2);
                default: result_next = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pointer, occupancy and completion-counter next state.
    // DEPTH is a power of two, so pointer increment wraps naturally.
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        done_cnt_next = done_cnt_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            if (done_cnt_reg != {CNT_W{1'b1}}) begin
                done_cnt_next = done_cnt_reg + CNT_W'(1);
            end
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + OCC_W'(1);
            2'b01:   count_next = count_reg - OCC_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            done_cnt_reg <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            done_cnt_reg <= done_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage entries. Each entry loads only when it is the push target.
    // Entries are cleared on reset so no stale data survives a restart.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    res_mem[gi] <= '0;
                    op_mem[gi]  <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    res_mem[gi] <= result_next;
                    op_mem[gi]  <= op;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Head outputs come from registered state only. They are forced to
    // zero while empty so the bus is clean after reset and after draining.
    // ------------------------------------------------------------------
    assign o        = out_valid ? res_mem[rd_ptr_reg] : '0;
    assign o_op     = out_valid ? op_mem[rd_ptr_reg]  : 2'b00;
    assign done_cnt = done_cnt_reg;

endmodule

// File: tb/tb_bitwise_stream_unit.sv
// -----------------------------------------------------------------------------
// tb_bitwise_stream_unit
//
// Directed scenarios followed by random traffic. Every cycle the DUT outputs
// are compared against a queue-based reference model of the FIFO. Directed
// steps add constant-value checks. The completion counter is narrowed so that
// saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_bitwise_stream_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] i_1;
    logic [WIDTH-1:0] i_2;
    logic             enable;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;
    logic [1:0]       o_op;
    logic [CNT_W-1:0] done_cnt;

    bitwise_stream_unit #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .i_1      (i_1),
        .i_2      (i_2),
        .enable   (enable),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .o        (o),
        .o_op     (o_op),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of {opcode, result}, plus popped count.
    typedef struct packed {
        logic [1:0]       opc;
        logic [WIDTH-1:0] res;
    } entry_t;

    entry_t     model_q[$];
    int         model_done = 0;
    bit         model_known = 0;
    int         cycle = 0;

    function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] opc,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic en);
        if (!en) return '0;
        case (opc)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    // One clock cycle. Called at a falling edge: drive inputs, compare the
    // registered outputs against the model, then advance the model across
    // the rising edge and return at the next falling edge.
    task automatic step(input logic r, input logic iv, input logic [1:0] opv,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic en, input logic ordy, output logic accepted);
        logic exp_push;
        logic exp_pop;
        entry_t e;
        rst       = r;
        in_valid  = iv;
        op        = opv;
        i_1       = a;
        i_2       = b;
        enable    = en;
        out_ready = ordy;
        #1;
        if (model_known) begin
            chk("in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            chk("done_cnt", 64'(done_cnt), 64'(model_done));
            if (model_q.size() != 0) begin
                chk("o", 64'(o), 64'(model_q[0].res));
                chk("o_op", 64'(o_op), 64'(model_q[0].opc));
            end
        end
        exp_push = !r && iv && (model_q.size() < DEPTH);
        exp_pop  = !r && ordy && (model_q.size() != 0);
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_done  = 0;
            model_known = 1;
        end else if (model_known) begin
            if (exp_pop) begin
                void'(model_q.pop_front());
                if (model_done < int'(CNT_MAX)) model_done++;
            end
            if (exp_push) begin
                e.opc = opv;
                e.res = ref_result(opv, a, b, en);
                model_q.push_back(e);
            end
        end
        accepted = exp_push;
        $display("cyc=%0d rst=%0b push=%0b pop=%0b op=%0d a=%h b=%h en=%0b occ=%0d done=%0d",
                 cycle, r, exp_push, exp_pop, opv, a, b, en, model_q.size(), model_done);
        cycle++;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, 1'b0, 2'd0, '0, '0, 1'b0, ordy, acc);
    endtask

    task automatic do_reset(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0, acc);
    endtask

    // Drain with a bounded number of cycles; an expired bound is a failure.
    task automatic drain();
        int guard;
        guard = 0;
        while (model_q.size() != 0 && guard < 4 * DEPTH) begin
            idle(1'b1);
            guard++;
        end
        chk("drain_bound", 64'(model_q.size()), 64'd0);
    endtask

    initial begin
        logic              acc;
        logic [WIDTH-1:0]  held_o;
        logic [WIDTH-1:0]  seq_exp [4];
        int                n_acc;
        int                first_pop_cyc;
        int                fifth_cyc;
        int                guard;
        logic [WIDTH-1:0]  wa;
        logic [WIDTH-1:0]  wb;

        rst = 1'b1; in_valid = 1'b0; op = '0; i_1 = '0; i_2 = '0;
        enable = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        // ---- Reset state ----
        do_reset(2);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_o", 64'(o), 64'd0);
        chk("rst_o_op", 64'(o_op), 64'd0);
        chk("rst_done", 64'(done_cnt), 64'd0);

        // ---- Basic OR ----
        step(1'b0, 1'b1, 2'b01, 32'h0000129F, 32'h00000BD2, 1'b1, 1'b0, acc);
        chk("or_o", 64'(o), 64'h00001BDF);
        chk("or_o_op", 64'(o_op), 64'd1);
        chk("or_valid", 64'(out_valid), 64'd1);
        idle(1'b1);
        chk("or_done", 64'(done_cnt), 64'd1);
        chk("or_empty", 64'(out_valid), 64'd0);

        // ---- All ops back to back with out_ready=1 ----
        seq_exp[0] = 32'hA8492525;
        seq_exp[1] = 32'hFFFFFFFF;
        seq_exp[2] = 32'h57B6DADA;
        seq_exp[3] = 32'h00000000;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 2'(k), 32'hFFFFFFFF, 32'hA8492525, 1'b1, 1'b1, acc);
            chk("allops_o", 64'(o), 64'(seq_exp[k]));
            chk("allops_op", 64'(o_op), 64'(k));
        end
        drain();

        // ---- Enable gating ----
        step(1'b0, 1'b1, 2'b01, 32'hFFA521FF, 32'h80000007, 1'b0, 1'b0, acc);
        chk("en0_o", 64'(o), 64'h0);
        chk("en0_valid", 64'(out_valid), 64'd1);
        step(1'b0, 1'b1, 2'b01, 32'hFFA521FF, 32'h80000007, 1'b1, 1'b1, acc);
        chk("en1_o", 64'(o), 64'hFFA521FF);
        drain();

        // ---- Full and back-pressure ----
        n_acc = 0;
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b1, 2'b10, 32'(n_acc + 1), 32'h5A5A0000, 1'b1, 1'b0, acc);
            if (acc) n_acc++;
        end
        chk("full_accepted", 64'(n_acc), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        first_pop_cyc = cycle;
        fifth_cyc = -1;
        guard = 0;
        while (n_acc < 5 && guard < 10) begin
            step(1'b0, 1'b1, 2'b10, 32'(n_acc + 1), 32'h5A5A0000, 1'b1, 1'b1, acc);
            if (acc) begin
                n_acc++;
                fifth_cyc = cycle - 1;
            end
            guard++;
        end
        chk("fifth_accept_cycle", 64'(fifth_cyc - first_pop_cyc), 64'd1);
        drain();

        // ---- Pointer wrap: 10 push/pop pairs ----
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 2'(k % 4), $urandom, $urandom, 1'b1, 1'b1, acc);
        end
        drain();

        // ---- Simultaneous push/pop at occupancy 2, then stall ----
        step(1'b0, 1'b1, 2'b00, 32'h11111111, 32'hFFFF0000, 1'b1, 1'b0, acc);
        step(1'b0, 1'b1, 2'b01, 32'h22220000, 32'h00002222, 1'b1, 1'b0, acc);
        step(1'b0, 1'b1, 2'b10, 32'h33333333, 32'h0000FFFF, 1'b1, 1'b1, acc);
        chk("simul_occ", 64'(model_q.size()), 64'd2);
        chk("simul_head", 64'(o), 64'h22222222);
        held_o = o;
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            chk("stall_o", 64'(o), 64'(held_o));
        end
        drain();

        // ---- Done counter saturation ----
        for (int k = 0; k < int'(CNT_MAX) + 3; k++) begin
            step(1'b0, 1'b1, 2'b11, $urandom, $urandom, 1'b1, 1'b1, acc);
        end
        drain();
        chk("done_sat", 64'(done_cnt), 64'(CNT_MAX));

        // ---- Reset mid-stream ----
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 2'b10, 32'hDEAD0000 + 32'(k), 32'h0000BEEF, 1'b1, 1'b0, acc);
        end
        step(1'b1, 1'b1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, acc);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_done", 64'(done_cnt), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_o", 64'(o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            chk("mid_rst_no_emit", 64'(out_valid), 64'd0);
        end

        // ---- Random traffic ----
        for (int k = 0; k < 400; k++) begin
            wa = $urandom;
            wb = $urandom;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), wa, wb, ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 2) != 0), acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
